// File: rtl/sfx_pkg.sv
// sfx_pkg: note periods, cue indices and types shared by the sound-effect scheduler
package sfx_pkg;
  localparam logic [31:0] C4   = 32'd191113;
  localparam logic [31:0] E4   = 32'd151686;
  localparam logic [31:0] G3   = 32'd255102;
  localparam logic [31:0] G4   = 32'd127552;
  localparam logic [31:0] C5   = 32'd95556;
  localparam logic [31:0] REST = 32'hFFFF_FFFF;
  localparam logic [1:0] CUE_CHARGE = 2'd0;
  localparam logic [1:0] CUE_JUMP   = 2'd1;
  localparam logic [1:0] CUE_HIT    = 2'd2;
  localparam logic [1:0] CUE_WIN    = 2'd3;
  typedef struct packed {
    logic [31:0] period;
    logic [3:0]  beats;
    logic        last;
  } note_t;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
endpackage

// File: rtl/sfx_cue_rom.sv
// sfx_cue_rom: combinational cue ROM mapping (cue, note index) to a note entry
module sfx_cue_rom
  import sfx_pkg::*;
(
  input  logic [1:0] cue,
  input  logic [2:0] idx,
  output note_t      entry
);
  always_comb begin
    entry = note_t'{REST, 4'd1, 1'b1};
    case ({cue, idx})
      {CUE_CHARGE, 3'd0}: entry = note_t'{C4,   4'd2, 1'b1};
      {CUE_JUMP,   3'd0}: entry = note_t'{C5,   4'd1, 1'b1};
      {CUE_HIT,    3'd0}: entry = note_t'{E4,   4'd1, 1'b0};
      {CUE_HIT,    3'd1}: entry = note_t'{C4,   4'd1, 1'b1};
      {CUE_WIN,    3'd0}: entry = note_t'{G3,   4'd1, 1'b0};
      {CUE_WIN,    3'd1}: entry = note_t'{C4,   4'd1, 1'b0};
      {CUE_WIN,    3'd2}: entry = note_t'{E4,   4'd1, 1'b0};
      {CUE_WIN,    3'd3}: entry = note_t'{G4,   4'd2, 1'b0};
      {CUE_WIN,    3'd4}: entry = note_t'{REST, 4'd2, 1'b1};
      default:            entry = note_t'{REST, 4'd1, 1'b1};
    endcase
  end
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: prioritised sound-effect arbiter sequencing cue notes onto one tone timer
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int                   NUM_REQ     = 4,
  parameter int                   BEAT_CYCLES = 10_000_000,
  parameter logic [NUM_REQ-1:0]   LOCK_MASK   = 4'b1000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mute,
  output logic [31:0]        tone_period,
  output logic               busy,
  output logic [1:0]         cue_active,
  output logic               cue_done,
  output logic [NUM_REQ-1:0] pending
);
  state_t             state, state_n;
  note_t              entry;
  logic [31:0]        period_reg, cyc_cnt;
  logic [3:0]         beat_left;
  logic [2:0]         note_idx;
  logic               last_reg, locked, grant, wrap, note_end, done;
  logic [1:0]         hi;
  logic [NUM_REQ-1:0] gmask;

  sfx_cue_rom u_rom (.cue(cue_active), .idx(note_idx), .entry(entry));

  assign busy        = state != IDLE;
  assign tone_period = mute ? REST : period_reg;

  // grant covers first start from IDLE, preemption by a higher cue and retrigger of the same cue
  always_comb begin
    hi = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pending[i]) hi = 2'(i);
    locked   = busy && LOCK_MASK[cue_active];
    grant    = |pending && (state == IDLE || (!locked && hi >= cue_active));
    gmask    = '0;
    if (grant) gmask[hi] = 1'b1;
    wrap     = cyc_cnt == 32'(BEAT_CYCLES - 1);
    note_end = state == PLAY && wrap && beat_left == 4'd1;
    done     = !grant && note_end && last_reg;
    state_n  = grant ? LOAD : state == LOAD ? PLAY : note_end ? (last_reg ? IDLE : LOAD) : state;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      period_reg <= REST;
      cyc_cnt    <= '0;
      beat_left  <= '0;
      note_idx   <= '0;
      last_reg   <= 1'b0;
      cue_active <= '0;
      cue_done   <= 1'b0;
      pending    <= '0;
    end else begin
      state    <= state_n;
      cue_done <= done;
      pending  <= (pending & ~gmask) | (locked ? '0 : req);
      if (grant) begin
        cue_active <= hi;
        note_idx   <= '0;
      end else if (state == LOAD) begin
        period_reg <= entry.period;
        beat_left  <= entry.beats == 4'd0 ? 4'd1 : entry.beats;
        last_reg   <= entry.last;
        cyc_cnt    <= '0;
      end else if (state == PLAY) begin
        cyc_cnt <= wrap ? '0 : cyc_cnt + 32'd1;
        if (wrap) beat_left <= beat_left - 4'd1;
        if (note_end && last_reg) period_reg <= REST;
        if (note_end && !last_reg) note_idx <= note_idx + 3'd1;
      end
    end
  end
endmodule
